squeeze_unpacker: RTL and testbench
===================================

Name: squeeze_unpacker

Overview:
- Output-side counterpart of the padder. The padder packs 32-bit input words into RATE-bit blocks for the Keccak core; this block takes RATE-bit squeezed blocks from the core and serialises them back into 32-bit words.
- It serves the Kyber XOF/PRF consumers (rejection sampler, CBD sampler).
- It delivers exactly the number of words requested and pulls further blocks from the core on demand.

Parameters:
- RATE, 576, block width in bits; must be a multiple of WORD.
- WORD, 32, output word width in bits.
- CNT_W, 16, width of the requested-word counter.

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- req_words  in  CNT_W  number of words to deliver; sampled with start
- blk_in  in  RATE  squeezed block from the core; word 0 = blk_in[RATE-1 -: WORD]
- blk_ready  in  1  blk_in is valid
- blk_ack  out  1  one-cycle pulse: block captured, core may advance
- out  out  WORD  output word
- out_valid  out  1  out holds a valid word
- out_ack  in  1  downstream accepts; transfer occurs when out_valid && out_ack
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last requested word transfers

Behaviour:
- Reset: state IDLE; out=0, out_valid=0, blk_ack=0, busy=0, done=0; shift register, word_idx and remaining cleared. Reset takes priority in every state. Reset mid-request discards all buffered words and issues no blk_ack and no done.
- Localparam WORDS = RATE/WORD (18 at defaults). word_idx is sized $clog2(WORDS).
- IDLE:
  - start with req_words>0: latch remaining=req_words, go to WAIT_BLK.
  - start with req_words==0: pulse done next cycle, stay in IDLE.
  - start outside IDLE is ignored.
- WAIT_BLK:
  - out_valid=0.
  - When blk_ready=1: capture blk_in into the shift register, clear word_idx, go to EMIT. blk_ack is registered and pulses in the cycle after capture, exactly once per captured block.
  - blk_ready is ignored in every other state.
- EMIT:
  - out = top WORD bits of the shift register; out_valid=1. The first word is valid 1 cycle after capture.
  - On transfer: shift the register left by WORD, word_idx+1, remaining-1.
  - If remaining reaches 0: out_valid=0 next cycle, done pulses, return to IDLE. Unread words of the block are dropped.
  - Else if the transfer was word WORDS-1: go to WAIT_BLK. A block boundary costs exactly one bubble cycle when blk_ready is already high.
  - Else: stay in EMIT. With out_ack held high, one word transfers per cycle.
- Backpressure: while out_valid && !out_ack, out and out_valid hold stable and nothing shifts.
- done and blk_ack never assert in the same cycle as reset.

Optional Feature:
- SQUEEZE_BYTE_SWAP_EN defined: out is the byte-reversed top word. Byte 0 of the word goes to out[7:0], giving the Keccak little-endian lane order that the samplers expect.
- SQUEEZE_BYTE_SWAP_EN undefined: out is the top word unchanged, MSB-first, matching the padder's packing order.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package kyber_keccak_pkg holds: RATE_SHA3_512=576, RATE_SHAKE128=1344, RATE_SHAKE256=1088, WORD=32, and the state encoding (IDLE, WAIT_BLK, EMIT).
- One natural sub-module: squeeze_shreg, a loadable RATE-bit left-shifting register with a top-word tap, load and shift enables.
- FSM and counters stay in squeeze_unpacker.

Test Plan:
- Reset: hold reset 3 cycles with random inputs -> out=0, out_valid=0, blk_ack=0, busy=0, done=0.
- Single block: req_words=18, blk_in={32'd0,32'd1,...,32'd17}, blk_ready=1, out_ack=1 -> out 0..17 on consecutive cycles, one blk_ack pulse, done the cycle after word 17, busy low afterwards.
- Two blocks with stall: req_words=20; second block {32'h100,...} raised 5 cycles late -> out_valid low during the wait, words 16,17 then 32'h100, 32'h101, two blk_ack pulses, done after 32'h101.
- Backpressure: req_words=4, out_ack pattern 1,0,0,1,0,1,1 -> out held stable while not acked, exactly 4 transfers in order 0,1,2,3.
- Zero request and ignored start: req_words=0 -> done pulses 1 cycle later, no blk_ack. A start issued in EMIT is ignored and does not change remaining.
- Reset mid-stream and byte swap: reset after 5 of 18 words -> outputs 0 next cycle, and a new request returns word 0 first. With SQUEEZE_BYTE_SWAP_EN, word 32'h01020304 -> out=32'h04030201.

Source files
------------

// File: rtl/kyber_keccak_pkg.sv
// rtl/kyber_keccak_pkg.sv - shared Keccak rates, word width and squeeze FSM encoding
package kyber_keccak_pkg;

  localparam int RATE_SHA3_512 = 576;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;
  localparam int WORD          = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    EMIT     = 2'd2
  } squeeze_state_t;

endpackage

// File: rtl/squeeze_shreg.sv
// rtl/squeeze_shreg.sv - loadable left-shifting block register with top-word tap
module squeeze_shreg #(
  parameter int RATE = 576,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift,
  input  logic [RATE-1:0] din,
  output logic [WORD-1:0] top
);

  logic [RATE-1:0] data;

  // load wins over shift; a shift moves the next word into the top slot
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= din;
    end else if (shift) begin
      data <= {data[RATE-WORD-1:0], {WORD{1'b0}}};
    end
  end

  assign top = data[RATE-1 -: WORD];

endmodule

// File: rtl/squeeze_unpacker.sv
// rtl/squeeze_unpacker.sv - serialises squeezed RATE-bit blocks into words; SQUEEZE_BYTE_SWAP_EN byte-reverses each word
module squeeze_unpacker #(
  parameter int RATE  = 576,
  parameter int WORD  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] req_words,
  input  logic [RATE-1:0]  blk_in,
  input  logic             blk_ready,
  output logic             blk_ack,
  output logic [WORD-1:0]  out,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             busy,
  output logic             done
);

  import kyber_keccak_pkg::*;

  localparam int WORDS = RATE / WORD;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  squeeze_state_t   state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [IDX_W-1:0] word_idx;
  logic [WORD-1:0]  top_word;
  logic             accept, zero_req, load, shift, last_word, blk_end;

  assign accept    = (state == IDLE) && start && (req_words != '0);
  assign zero_req  = (state == IDLE) && start && (req_words == '0);
  assign load      = (state == WAIT_BLK) && blk_ready;
  assign shift     = (state == EMIT) && out_ack;
  assign last_word = (remaining == CNT_W'(1));
  assign blk_end   = (word_idx == IDX_W'(WORDS - 1));

  squeeze_shreg #(
    .RATE (RATE),
    .WORD (WORD)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (blk_in),
    .top   (top_word)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state plus level outputs derived from the current state
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT_BLK;
      end
      WAIT_BLK: begin
        busy = 1'b1;
        if (blk_ready) state_nxt = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ack) begin
          if (last_word)    state_nxt = IDLE;
          else if (blk_end) state_nxt = WAIT_BLK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // remaining-word and in-block word counters
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      word_idx  <= '0;
    end else begin
      if (accept) remaining <= req_words;
      if (load)   word_idx  <= '0;
      if (shift) begin
        remaining <= remaining - 1'b1;
        word_idx  <= word_idx + 1'b1;
      end
    end
  end

  // registered one-cycle pulses: block consumed, request finished
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_ack <= 1'b0;
      done    <= 1'b0;
    end else begin
      blk_ack <= load;
      done    <= zero_req || (shift && last_word);
    end
  end

  // presented word, zero whenever nothing is being offered
  always_comb begin
    out = '0;
    if (out_valid) begin
`ifdef SQUEEZE_BYTE_SWAP_EN
      for (int b = 0; b < WORD / 8; b++) begin
        out[8*b +: 8] = top_word[WORD-1-8*b -: 8];
      end
`else
      out = top_word;
`endif
    end
  end

endmodule

// File: tb/tb_squeeze_unpacker.sv
// tb/tb_squeeze_unpacker.sv - randomized self-checking bench for squeeze_unpacker
module tb_squeeze_unpacker;

  localparam int RATE  = 576;
  localparam int WORD  = 32;
  localparam int CNT_W = 16;
  localparam int WORDS = RATE / WORD;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] req_words = '0;
  logic [RATE-1:0]  blk_in = '0;
  logic             blk_ready = 1'b0;
  logic             blk_ack;
  logic [WORD-1:0]  out;
  logic             out_valid;
  logic             out_ack = 1'b0;
  logic             busy;
  logic             done;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] blk_words[$];

  squeeze_unpacker #(.RATE(RATE), .WORD(WORD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .req_words (req_words),
    .blk_in    (blk_in),
    .blk_ready (blk_ready),
    .blk_ack   (blk_ack),
    .out       (out),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef SQUEEZE_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // block k as the core presents it: word 0 in the top bits
  function automatic logic [RATE-1:0] pack_block(input int k);
    logic [RATE-1:0] v = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (k * WORDS + i < blk_words.size())
        v[RATE-1-WORD*i -: WORD] = blk_words[k * WORDS + i];
    end
    return v;
  endfunction

  task automatic fill_random(input int n);
    blk_words.delete();
    for (int i = 0; i < n; i++) blk_words.push_back($urandom);
  endtask

  // ack_mode: 0 always, 1 random, 2 fixed pattern; ready_mode: 0 gated by late, 1 random
  task automatic run_req(input int req, input int ack_mode, input int ready_mode,
                         input int late, input bit poke_start, input int exp_lat);
    int nblk = (req + WORDS - 1) / WORDS;
    logic [31:0] exp_q[$];
    int got = 0, acks = 0, cyc = 0, first_valid = -1, last_xfer = -1, gap = 0, pidx = 0;
    int end_cyc = 0;
    bit done_seen = 0, prev_hold = 0, poked = 0, ack, rdy;
    logic [31:0] prev_out = '0;
    bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    for (int j = 0; j < req; j++) exp_q.push_back(model_word(blk_words[j]));
    blk_in = pack_block(0);
    blk_ready = 1'b0;
    start = 1'b1;
    req_words = CNT_W'(req);
    step();
    start = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 3000) begin
      if (blk_ack) acks++;
      if (done) begin
        done_seen = 1;
        vectors++;
        if (got !== req || cyc !== last_xfer + 1) begin
          errors++;
          $display("FAIL done_timing: transfers %0d at cycle %0d, required %0d with done at cycle %0d", got, cyc, req, last_xfer + 1);
        end
        vectors++;
        if (acks !== nblk) begin
          errors++;
          $display("FAIL blk_ack_count: got %0d, required %0d", acks, nblk);
        end
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_after_done: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        break;
      end
      if (prev_hold) begin
        vectors++;
        if (out_valid !== 1'b1 || out !== prev_out) begin
          errors++;
          $display("FAIL hold_stable: out_valid=%b out=%h, required 1 %h", out_valid, out, prev_out);
        end
      end
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (out_valid !== 1'b1 && got > 0 && got < req) gap++;
      blk_in = pack_block(acks);
      if (ready_mode == 1) rdy = ($urandom_range(0, 1) == 1);
      else rdy = (acks == 0) || (got >= acks * WORDS && cyc - end_cyc >= late + 1);
      blk_ready = rdy;
      if (ack_mode == 0) ack = 1;
      else if (ack_mode == 1) ack = ($urandom_range(0, 3) != 0);
      else if (first_valid < 0) ack = 1;
      else begin
        ack = (pidx < 7) ? pat[pidx] : 1'b1;
        pidx++;
      end
      out_ack = ack;
      if (poke_start && out_valid === 1'b1 && !poked) begin
        start = 1'b1;
        req_words = CNT_W'($urandom_range(20, 200));
        poked = 1;
      end else begin
        start = 1'b0;
      end
      if (out_valid === 1'b1 && ack) begin
        vectors++;
        if (got >= req) begin
          errors++;
          $display("FAIL extra_word: transfer %0d, required only %0d", got + 1, req);
        end else if (out !== exp_q[got]) begin
          errors++;
          $display("FAIL word[%0d]: got %h, required %h", got, out, exp_q[got]);
        end
        got++;
        last_xfer = cyc;
        if (got % WORDS == 0) end_cyc = cyc;
      end
      prev_hold = (out_valid === 1'b1) && !ack;
      prev_out = out;
      step();
      cyc++;
    end
    if (!done_seen) begin
      vectors++;
      errors++;
      $display("FAIL done_timeout: got %0d words, required %0d and done", got, req);
    end
    if (exp_lat >= 0) begin
      vectors++;
      if (first_valid !== exp_lat) begin
        errors++;
        $display("FAIL first_latency: got %0d, required %0d", first_valid, exp_lat);
      end
    end
    if (ack_mode == 0 && ready_mode == 0) begin
      vectors++;
      if (gap !== (late + 1) * (nblk - 1)) begin
        errors++;
        $display("FAIL boundary_gap: got %0d idle cycles, required %0d", gap, (late + 1) * (nblk - 1));
      end
    end
    start = 1'b0;
    out_ack = 1'b0;
    blk_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom);
      req_words = CNT_W'($urandom);
      blk_in = {18{32'($urandom)}};
      blk_ready = 1'($urandom);
      out_ack = 1'($urandom);
      step();
    end
    vectors++;
    if (out !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: out=%h out_valid=%b, required 0 0", out, out_valid);
    end
    vectors++;
    if (blk_ack !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: blk_ack=%b busy=%b done=%b, required 0 0 0", blk_ack, busy, done);
    end
    start = 1'b0;
    blk_ready = 1'b0;
    out_ack = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_block();
    blk_words.delete();
    for (int i = 0; i < WORDS; i++) blk_words.push_back(32'(i));
    run_req(WORDS, 0, 0, 0, 0, 2);
  endtask

  task automatic test_two_blocks_stall();
    blk_words.delete();
    for (int i = 0; i < WORDS; i++) blk_words.push_back(32'(i));
    for (int i = 0; i < WORDS; i++) blk_words.push_back(32'h100 + 32'(i));
    run_req(20, 0, 0, 5, 0, 2);
    fill_random(3 * WORDS);
    run_req(3 * WORDS, 0, 0, 0, 0, 2);
  endtask

  task automatic test_backpressure();
    blk_words.delete();
    for (int i = 0; i < WORDS; i++) blk_words.push_back(32'(i));
    run_req(4, 2, 0, 0, 0, 2);
  endtask

  task automatic test_zero_and_ignored();
    start = 1'b1;
    req_words = '0;
    step();
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || blk_ack !== 1'b0) begin
      errors++;
      $display("FAIL zero_req: done=%b busy=%b blk_ack=%b, required 1 0 0", done, busy, blk_ack);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_req_pulse: done=%b, required 0", done);
    end
    fill_random(WORDS);
    run_req(5, 0, 0, 0, 1, 2);
  endtask

  task automatic test_reset_mid();
    int got = 0;
    blk_words.delete();
    for (int i = 0; i < WORDS; i++) blk_words.push_back(32'(i));
    blk_in = pack_block(0);
    blk_ready = 1'b1;
    out_ack = 1'b1;
    start = 1'b1;
    req_words = CNT_W'(WORDS);
    step();
    start = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (out_valid === 1'b1) got++;
      if (got == 5) reset = 1'b1;
      step();
    end
    vectors++;
    if (out !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || blk_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%h valid=%b busy=%b done=%b ack=%b, required all 0", out, out_valid, busy, done, blk_ack);
    end
    reset = 1'b0;
    out_ack = 1'b0;
    blk_ready = 1'b0;
    step();
    vectors++;
    if (done !== 1'b0 || blk_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulses: done=%b blk_ack=%b, required 0 0", done, blk_ack);
    end
    fill_random(WORDS);
    run_req(3, 0, 0, 0, 0, 2);
  endtask

  task automatic test_byte_swap();
    logic [31:0] req_val;
`ifdef SQUEEZE_BYTE_SWAP_EN
    req_val = 32'h04030201;
`else
    req_val = 32'h01020304;
`endif
    fill_random(WORDS);
    blk_words[0] = 32'h01020304;
    blk_in = pack_block(0);
    blk_ready = 1'b1;
    start = 1'b1;
    req_words = 16'd1;
    step();
    start = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out !== req_val) begin
      errors++;
      $display("FAIL byte_order: out_valid=%b out=%h, required 1 %h", out_valid, out, req_val);
    end
    out_ack = 1'b1;
    blk_ready = 1'b0;
    step();
    out_ack = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL byte_order_done: done=%b, required 1", done);
    end
    step();
  endtask

  task automatic test_random();
    for (int t = 0; t < 15; t++) begin
      int req = $urandom_range(1, 60);
      fill_random(4 * WORDS);
      run_req(req, 1, 1, 0, t[0], -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_two_blocks_stall();
    test_backpressure();
    test_zero_and_ignored();
    test_reset_mid();
    test_byte_swap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
